// File: rtl/mknf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mknf_pkg
// Purpose  : Shared types, forward code table and helper for the inverse
//            search of the 4-bit converter F.
// Revision : 1.0 - initial release
// ============================================================================
package mknf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Forward map F(X), indexed by X = 0..15
  localparam logic [3:0] F_TABLE [16] = '{
    4'hC, 4'hA, 4'h2, 4'h5, 4'hC, 4'h7, 4'hD, 4'h2,
    4'h2, 4'h7, 4'h0, 4'h3, 4'h8, 4'h4, 4'h4, 4'h0
  };

  localparam logic [3:0] CAND_LAST = 4'hF;

  function automatic logic [3:0] mknf_f(input logic [3:0] x);
    return F_TABLE[x];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mknf_inv_search_if.sv
`default_nettype none
// ============================================================================
// Module   : mknf_inv_search_if
// Purpose  : Request (Y) and result (X preimage) valid/ready streams.
// Revision : 1.0 - initial release
// ============================================================================
interface mknf_inv_search_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_x;
  logic       out_last;
  logic       out_none;
  logic [4:0] out_count;

  // Block side: consumes requests, produces result beats
  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_x, out_last, out_none, out_count
  );

  // Environment side: issues requests, sinks result beats
  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_x, out_last, out_none, out_count
  );
endinterface
`default_nettype wire

// File: rtl/mknf_inv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mknf_inv_ctrl
// Purpose  : Sweep FSM for the inverse search; owns candidate, beat index and
//            match count, and tells the top when to load a result beat.
// Revision : 1.0 - initial release
// ============================================================================
module mknf_inv_ctrl
  import mknf_pkg::*;
#(
  parameter bit FIRST_ONLY = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_in_valid,
  input  wire logic       i_out_ready,
  input  wire logic       i_hit,         // F(o_eval_cand) == requested Y
  input  wire logic       i_beat_last,   // beat currently presented is last
  output logic            o_in_ready,
  output logic            o_out_valid,
  output logic            o_accept,
  output logic [3:0]      o_eval_cand,
  output logic            o_load,
  output logic            o_load_last,
  output logic            o_load_none,
  output logic [4:0]      o_load_count
);

  state_t     r_state, w_state_n;
  logic [3:0] r_cand,  w_cand_n;
  logic [4:0] r_idx,   w_idx_n;
  logic [4:0] r_count, w_count_n;
  logic [4:0] w_count_inc;

  assign w_count_inc = r_count + {4'd0, i_hit};
  assign o_in_ready  = (r_state == IDLE) && !rst;
  assign o_out_valid = (r_state == OUT);

  // State and sweep registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cand  <= 4'd0;
      r_idx   <= 5'd0;
      r_count <= 5'd0;
    end else begin
      r_state <= w_state_n;
      r_cand  <= w_cand_n;
      r_idx   <= w_idx_n;
      r_count <= w_count_n;
    end
  end

  // Next-state, sweep bookkeeping and beat-load decisions
  always_comb begin
    w_state_n    = r_state;
    w_cand_n     = r_cand;
    w_idx_n      = r_idx;
    w_count_n    = r_count;
    o_accept     = 1'b0;
    o_eval_cand  = r_cand;
    o_load       = 1'b0;
    o_load_last  = 1'b0;
    o_load_none  = 1'b0;
    o_load_count = 5'd0;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          o_accept  = 1'b1;
          w_cand_n  = 4'd0;
          w_idx_n   = 5'd0;
          w_count_n = 5'd0;
          w_state_n = FIRST_ONLY ? SCAN : COUNT;
        end
      end
      COUNT: begin
        w_count_n = w_count_inc;
        if (r_cand == CAND_LAST) begin
          if (w_count_inc == 5'd0) begin
            o_load      = 1'b1;
            o_load_none = 1'b1;
            o_load_last = 1'b1;
            w_state_n   = OUT;
          end else begin
            w_cand_n  = 4'd0;
            w_state_n = SCAN;
          end
        end else begin
          w_cand_n = r_cand + 4'd1;
        end
      end
      SCAN: begin
        if (i_hit) begin
          o_load       = 1'b1;
          o_load_last  = FIRST_ONLY ? 1'b1 : (r_idx + 5'd1 == r_count);
          o_load_count = FIRST_ONLY ? 5'd1 : r_count;
          w_state_n    = OUT;
        end else if (r_cand == CAND_LAST) begin
          // Only reachable without a count pass (empty preimage set)
          o_load      = 1'b1;
          o_load_none = 1'b1;
          o_load_last = 1'b1;
          w_state_n   = OUT;
        end else begin
          w_cand_n = r_cand + 4'd1;
        end
      end
      OUT: begin
        // The handshake cycle also tests cand+1, so adjacent hits go out
        // back-to-back and a beat for X always lands 18+X after acceptance.
        o_eval_cand = r_cand + 4'd1;
        if (i_out_ready) begin
          if (i_beat_last) begin
            w_state_n = IDLE;
          end else begin
            w_idx_n = r_idx + 5'd1;
            if (i_hit) begin
              o_load       = 1'b1;
              o_load_last  = (r_idx + 5'd2 == r_count);
              o_load_count = r_count;
              w_cand_n     = r_cand + 4'd1;
            end else begin
              // cand+1 already missed; more hits remain so cand+2 <= 15
              w_cand_n  = r_cand + 4'd2;
              w_state_n = SCAN;
            end
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mknf_inv_search.sv
`default_nettype none
// ============================================================================
// Module   : mknf_inv_search
// Purpose  : Streams the full preimage set {X : F(X) = Y} of a requested Y in
//            ascending order, or a single "none" beat when it is empty.
// Revision : 1.0 - initial release
// ============================================================================
module mknf_inv_search
  import mknf_pkg::*;
#(
  parameter bit FIRST_ONLY = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mknf_inv_search_if.slave   bus
);

  logic       w_accept;
  logic       w_out_valid;
  logic       w_in_ready;
  logic [3:0] w_eval_cand;
  logic       w_hit;
  logic       w_load;
  logic       w_load_last;
  logic       w_load_none;
  logic [4:0] w_load_count;

  logic [3:0] r_y_q;
  logic [3:0] r_out_x;
  logic       r_out_last;
  logic       r_out_none;
  logic [4:0] r_out_count;

  assign w_hit = (mknf_f(w_eval_cand) == r_y_q);

  mknf_inv_ctrl #(.FIRST_ONLY(FIRST_ONLY)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (bus.in_valid),
    .i_out_ready  (bus.out_ready),
    .i_hit        (w_hit),
    .i_beat_last  (r_out_last),
    .o_in_ready   (w_in_ready),
    .o_out_valid  (w_out_valid),
    .o_accept     (w_accept),
    .o_eval_cand  (w_eval_cand),
    .o_load       (w_load),
    .o_load_last  (w_load_last),
    .o_load_none  (w_load_none),
    .o_load_count (w_load_count)
  );

  // Latch Y at acceptance and the result beat whenever the FSM loads one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q       <= 4'd0;
      r_out_x     <= 4'd0;
      r_out_last  <= 1'b0;
      r_out_none  <= 1'b0;
      r_out_count <= 5'd0;
    end else begin
      if (w_accept) begin
        r_y_q <= bus.in_y;
      end
      if (w_load) begin
        r_out_x     <= w_load_none ? 4'd0 : w_eval_cand;
        r_out_last  <= w_load_last;
        r_out_none  <= w_load_none;
        r_out_count <= w_load_count;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_x     = r_out_x;
  assign bus.out_last  = r_out_last;
  assign bus.out_none  = r_out_none;
  assign bus.out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_mknf_inv_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_mknf_inv_search
// Purpose  : Scoreboard bench for mknf_inv_search, full-set (dut0) and
//            first-only (dut1) variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mknf_inv_search;
  import mknf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mknf_inv_search_if if0();
  mknf_inv_search_if if1();

  mknf_inv_search #(.FIRST_ONLY(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mknf_inv_search #(.FIRST_ONLY(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    logic [3:0] x;
    logic       last;
    logic       none;
    logic [4:0] cnt;
    int         at;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int sel, input logic [3:0] x, input logic last,
                      input logic none, input logic [4:0] cnt, input int at);
    beat_t b;
    b.x = x; b.last = last; b.none = none; b.cnt = cnt; b.at = at;
    if (sel == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold under stall
  logic       p_valid [2];
  logic       p_ready [2];
  logic [3:0] p_x     [2];
  logic       p_last  [2];
  logic       p_none  [2];
  logic [4:0] p_cnt   [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic       v, r, l, n;
      logic [3:0] x;
      logic [4:0] c;
      beat_t      e;
      int         qs;
      if (k == 0) begin
        v = if0.out_valid; r = if0.out_ready; x = if0.out_x;
        l = if0.out_last;  n = if0.out_none;  c = if0.out_count; qs = q0.size();
      end else begin
        v = if1.out_valid; r = if1.out_ready; x = if1.out_x;
        l = if1.out_last;  n = if1.out_none;  c = if1.out_count; qs = q1.size();
      end
      if (rst) begin
        p_valid[k] = 1'b0;
        p_ready[k] = 1'b1;
      end else begin
        if (v && p_valid[k] && !p_ready[k]) begin
          chk($sformatf("hold_x%0d", k),    x, p_x[k]);
          chk($sformatf("hold_last%0d", k), l, p_last[k]);
          chk($sformatf("hold_none%0d", k), n, p_none[k]);
          chk($sformatf("hold_cnt%0d", k),  c, p_cnt[k]);
        end
        if (v && r) begin
          if (qs == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_beat%0d: got x=%0d last=%0d none=%0d required no beat (cycle %0d)",
                     k, x, l, n, cyc + 1);
          end else begin
            if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("beat_x%0d", k),    x, e.x);
            chk($sformatf("beat_last%0d", k), l, e.last);
            chk($sformatf("beat_none%0d", k), n, e.none);
            chk($sformatf("beat_cnt%0d", k),  c, e.cnt);
            if (e.at >= 0) chk($sformatf("beat_cycle%0d", k), cyc + 1, e.at);
          end
        end
        p_valid[k] = v; p_ready[k] = r; p_x[k] = x;
        p_last[k] = l;  p_none[k] = n;  p_cnt[k] = c;
      end
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  // Present Y; returns the acceptance edge number
  task automatic send(input int sel, input logic [3:0] y, input bit hold, output int acc);
    if (sel == 0) begin if0.in_valid = 1'b1; if0.in_y = y; end
    else          begin if1.in_valid = 1'b1; if1.in_y = y; end
    acc = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      @(negedge clk);
      if (rdy(sel)) acc = cyc + 1;
    end
    if (acc < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout%0d: got no acceptance required acceptance within 200 cycles", sel);
      acc = cyc;
    end
    @(posedge clk); #1;
    if (!hold) begin
      if (sel == 0) if0.in_valid = 1'b0; else if1.in_valid = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input int sel);
    int left;
    left = (sel == 0) ? q0.size() : q1.size();
    for (int i = 0; i < 300 && left != 0; i++) begin
      @(negedge clk); #1;
      left = (sel == 0) ? q0.size() : q1.size();
    end
    if (left != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout%0d: got %0d beats outstanding required 0", sel, left);
      if (sel == 0) q0.delete(); else q1.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test required end before time limit");
    $fatal(1);
  end

  initial begin
    int acc, acc2, n, k;
    logic [3:0] xv;
    if0.in_valid = 1'b0; if0.in_y = 4'd0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_y = 4'd0; if1.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  if0.in_ready, 0);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_out_x",     if0.out_x, 0);
    chk("rst_out_last",  if0.out_last, 0);
    chk("rst_out_none",  if0.out_none, 0);
    chk("rst_out_count", if0.out_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", if0.in_ready, 1);
    @(posedge clk); #1;

    // Y=2: x=2,7,8 at 20,25,26; idle again for acceptance at 27
    send(0, 4'h2, 0, acc);
    push(0, 4'h2, 0, 0, 5'd3, acc + 20);
    push(0, 4'h7, 0, 0, 5'd3, acc + 25);
    push(0, 4'h8, 1, 0, 5'd3, acc + 26);
    wait_cyc(acc + 25);
    chk("y2_busy_in_ready", if0.in_ready, 0);
    @(negedge clk);
    chk("y2_idle_in_ready", if0.in_ready, 1);
    drain(0);

    // Y=1: empty set
    send(0, 4'h1, 0, acc);
    push(0, 4'h0, 1, 1, 5'd0, acc + 17);
    drain(0);

    // Y=C with five stalled cycles on the first beat
    send(0, 4'hC, 0, acc);
    if0.out_ready = 1'b0;
    push(0, 4'h0, 0, 0, 5'd2, acc + 23);
    push(0, 4'h4, 1, 0, 5'd2, acc + 27);
    wait_cyc(acc + 17);
    chk("bp_valid_first", if0.out_valid, 1);
    wait_cyc(acc + 21);
    @(posedge clk); #1;
    if0.out_ready = 1'b1;
    drain(0);

    // First-only variant: Y=7 -> x=5 at 7, Y=E -> none at 17
    send(1, 4'h7, 0, acc);
    push(1, 4'h5, 1, 0, 5'd1, acc + 7);
    drain(1);
    send(1, 4'hE, 0, acc);
    push(1, 4'h0, 1, 1, 5'd0, acc + 17);
    drain(1);

    // Reset during SCAN of Y=4 aborts it
    send(0, 4'h4, 0, acc);
    wait_cyc(acc + 20);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", if0.out_valid, 0);
    chk("midrst_in_ready",  if0.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rel_in_ready",  if0.in_ready, 1);
    chk("midrst_rel_out_count", if0.out_count, 0);
    @(posedge clk); #1;
    send(0, 4'h3, 0, acc);
    push(0, 4'hB, 1, 0, 5'd1, acc + 29);
    drain(0);

    // Back-to-back with in_valid held and in_y changing mid-request
    send(0, 4'h5, 1, acc);
    push(0, 4'h3, 1, 0, 5'd1, acc + 21);
    if0.in_y = 4'h0;
    send(0, 4'h0, 0, acc2);
    if0.in_y = 4'h7;
    chk("b2b_accept_cycle", acc2, acc + 22);
    push(0, 4'hA, 0, 0, 5'd2, acc2 + 28);
    push(0, 4'hF, 1, 0, 5'd2, acc2 + 33);
    drain(0);

    // Sweep every Y on both variants against the reference map
    for (int y = 0; y < 16; y++) begin
      send(0, 4'(y), 0, acc);
      n = 0;
      for (int x = 0; x < 16; x++) begin
        xv = 4'(x);
        if (mknf_f(xv) == 4'(y)) n++;
      end
      k = 0;
      for (int x = 0; x < 16; x++) begin
        xv = 4'(x);
        if (mknf_f(xv) == 4'(y)) begin
          k++;
          push(0, xv, (k == n), 0, 5'(n), acc + 18 + x);
        end
      end
      if (n == 0) push(0, 4'h0, 1, 1, 5'd0, acc + 17);
      drain(0);

      send(1, 4'(y), 0, acc);
      k = -1;
      for (int x = 15; x >= 0; x--) begin
        xv = 4'(x);
        if (mknf_f(xv) == 4'(y)) k = x;
      end
      if (k >= 0) push(1, 4'(k), 1, 0, 5'd1, acc + 2 + k);
      else        push(1, 4'h0, 1, 1, 5'd0, acc + 17);
      drain(1);
    end

    // Quiet tail: any stray beat is flagged by the monitor
    repeat (40) @(negedge clk);
    chk("tail_q0_empty", q0.size(), 0);
    chk("tail_q1_empty", q1.size(), 0);
    chk("tail_out_valid0", if0.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
